// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//
// Final pipeline stage. It registers the MEM-stage instruction and produces
// the register-file write port: enable, address and data. The data mux picks
// the ALU result, the load result or the link address (PC+8). Load results
// are extracted little-endian and sign- or zero-extended according to the
// load type.
//
// Parameters
//   DATA_W  datapath width in bits (multiple of 16, minimum 32)
//   REG_AW  register-file address width
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   StallW                  hold every stage register
//   FlushW                  clear ValidW/RegWriteW of the incoming instruction
//   ValidM, RegWriteM       instruction is real / writes the register file
//   ResultSrcM[1:0]         00 ALU, 01 memory, 10 link, 11 ALU
//   LoadTypeM[2:0]          000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, else LW
//   ByteOffM[1:0]           low address bits of the load
//   ALUOutM, ReadDataM,
//   PCPlus8M                candidate result values
//   WriteRegM               destination register
//   ValidW, RegWriteW,
//   WriteRegW, ResultW      register-file write port (WriteRegW also feeds
//                           the hazard unit)
//
// Optional feature (macro WB_HOLD_BYPASS_EN)
//   HoldValidW, HoldRegW,
//   HoldResultW             previous cycle's write-port values, kept for
//                           decode-stage forwarding
// ---------------------------------------------------------------------------
module writeback_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              StallW,
   input  logic              FlushW,
   input  logic              ValidM,
   input  logic              RegWriteM,
   input  logic [1:0]        ResultSrcM,
   input  logic [2:0]        LoadTypeM,
   input  logic [1:0]        ByteOffM,
   input  logic [DATA_W-1:0] ALUOutM,
   input  logic [DATA_W-1:0] ReadDataM,
   input  logic [DATA_W-1:0] PCPlus8M,
   input  logic [REG_AW-1:0] WriteRegM,
   output logic              ValidW,
   output logic              RegWriteW,
   output logic [REG_AW-1:0] WriteRegW,
   output logic [DATA_W-1:0] ResultW
`ifdef WB_HOLD_BYPASS_EN
   ,
   output logic              HoldValidW,
   output logic [REG_AW-1:0] HoldRegW,
   output logic [DATA_W-1:0] HoldResultW
`endif
);

   localparam logic [1:0] SRC_MEM  = 2'b01;
   localparam logic [1:0] SRC_LINK = 2'b10;

   localparam logic [2:0] LT_LH  = 3'b001;
   localparam logic [2:0] LT_LHU = 3'b010;
   localparam logic [2:0] LT_LB  = 3'b011;
   localparam logic [2:0] LT_LBU = 3'b100;

   logic              valid_r;
   logic              regwrite_r;
   logic [1:0]        resultsrc_r;
   logic [2:0]        loadtype_r;
   logic [1:0]        byteoff_r;
   logic [DATA_W-1:0] aluout_r;
   logic [DATA_W-1:0] readdata_r;
   logic [DATA_W-1:0] pcplus8_r;
   logic [REG_AW-1:0] writereg_r;

   logic [15:0]       half_sel;
   logic [7:0]        byte_sel;
   logic [DATA_W-1:0] load_data;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r     <= 1'b0;
         regwrite_r  <= 1'b0;
         resultsrc_r <= '0;
         loadtype_r  <= '0;
         byteoff_r   <= '0;
         aluout_r    <= '0;
         readdata_r  <= '0;
         pcplus8_r   <= '0;
         writereg_r  <= '0;
      end else begin
         // Flush only kills the enables; it wins over stall.
         if (FlushW) begin
            valid_r    <= 1'b0;
            regwrite_r <= 1'b0;
         end else if (!StallW) begin
            valid_r    <= ValidM;
            regwrite_r <= RegWriteM;
         end
         // Data fields follow the stall alone, so ResultW/WriteRegW keep the
         // last captured values while the enables are low.
         if (!StallW) begin
            resultsrc_r <= ResultSrcM;
            loadtype_r  <= LoadTypeM;
            byteoff_r   <= ByteOffM;
            aluout_r    <= ALUOutM;
            readdata_r  <= ReadDataM;
            pcplus8_r   <= PCPlus8M;
            writereg_r  <= WriteRegM;
         end
      end
   end

   // NOTE: every variable gets a default at the top of the always_comb so no
   // path through the case statements can leave it unassigned (no latches).
   always_comb begin
      half_sel  = readdata_r[{byteoff_r[1], 4'b0000} +: 16];
      byte_sel  = readdata_r[{byteoff_r, 3'b000} +: 8];
      load_data = readdata_r;
      unique case (loadtype_r)
         LT_LH:   load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
         LT_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
         LT_LB:   load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         LT_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
         default: load_data = readdata_r;
      endcase
   end

   always_comb begin
      ResultW = aluout_r;
      unique case (resultsrc_r)
         SRC_MEM:  ResultW = load_data;
         SRC_LINK: ResultW = pcplus8_r;
         default:  ResultW = aluout_r;
      endcase
   end

   assign ValidW    = valid_r;
   assign WriteRegW = writereg_r;
   // Register 0 is hard-wired zero, so a write to it is never issued.
   assign RegWriteW = regwrite_r & valid_r & (writereg_r != '0);

`ifdef WB_HOLD_BYPASS_EN
   // One-deep history of the write port, so decode can still forward a value
   // whose register-file write happened on the previous edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         HoldValidW  <= 1'b0;
         HoldRegW    <= '0;
         HoldResultW <= '0;
      end else if (!StallW) begin
         HoldValidW  <= RegWriteW;
         HoldRegW    <= WriteRegW;
         HoldResultW <= ResultW;
      end
   end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
//
// Self-checking bench for writeback_stage (DATA_W=32, REG_AW=5). A table of
// single-cycle vectors covers the result mux and load extraction; hand-written
// sequences cover stall/flush, the hold-bypass registers (when
// WB_HOLD_BYPASS_EN is defined), and asynchronous reset including reset
// during a stall. Expected write-port values are queued when stimulus is
// driven and popped when the registered output is sampled.
// ---------------------------------------------------------------------------
module tb_writeback_stage;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   logic              clk;
   logic              rst_n;
   logic              StallW;
   logic              FlushW;
   logic              ValidM;
   logic              RegWriteM;
   logic [1:0]        ResultSrcM;
   logic [2:0]        LoadTypeM;
   logic [1:0]        ByteOffM;
   logic [DATA_W-1:0] ALUOutM;
   logic [DATA_W-1:0] ReadDataM;
   logic [DATA_W-1:0] PCPlus8M;
   logic [REG_AW-1:0] WriteRegM;
   logic              ValidW;
   logic              RegWriteW;
   logic [REG_AW-1:0] WriteRegW;
   logic [DATA_W-1:0] ResultW;
`ifdef WB_HOLD_BYPASS_EN
   logic              HoldValidW;
   logic [REG_AW-1:0] HoldRegW;
   logic [DATA_W-1:0] HoldResultW;
`endif

   writeback_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .StallW     (StallW),
      .FlushW     (FlushW),
      .ValidM     (ValidM),
      .RegWriteM  (RegWriteM),
      .ResultSrcM (ResultSrcM),
      .LoadTypeM  (LoadTypeM),
      .ByteOffM   (ByteOffM),
      .ALUOutM    (ALUOutM),
      .ReadDataM  (ReadDataM),
      .PCPlus8M   (PCPlus8M),
      .WriteRegM  (WriteRegM),
      .ValidW     (ValidW),
      .RegWriteW  (RegWriteW),
      .WriteRegW  (WriteRegW),
      .ResultW    (ResultW)
`ifdef WB_HOLD_BYPASS_EN
      ,
      .HoldValidW (HoldValidW),
      .HoldRegW   (HoldRegW),
      .HoldResultW(HoldResultW)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        rw;
      logic [1:0]  src;
      logic [2:0]  lt;
      logic [1:0]  off;
      logic [31:0] alu;
      logic [31:0] rd;
      logic [31:0] pc8;
      logic [4:0]  wreg;
      logic [31:0] e_res;
      logic        e_rw;
      logic        e_v;
   } vec_t;

   typedef struct {
      logic        v;
      logic        rw;
      logic [4:0]  wreg;
      logic [31:0] res;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_out(input logic v, input logic rw, input logic [4:0] wreg,
                             input logic [31:0] res);
      exp_t e;
      e.v = v; e.rw = rw; e.wreg = wreg; e.res = res;
      sb.push_back(e);
   endtask

   task automatic compare_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
      end else begin
         e = sb.pop_front();
         check({tag, ".ValidW"},    32'(ValidW),    32'(e.v));
         check({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(e.rw));
         check({tag, ".WriteRegW"}, 32'(WriteRegW), 32'(e.wreg));
         check({tag, ".ResultW"},   ResultW,        e.res);
      end
   endtask

   task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                        input logic [2:0] lt, input logic [1:0] off,
                        input logic [31:0] alu, input logic [31:0] rd,
                        input logic [31:0] pc8, input logic [4:0] wreg);
      ValidM = v; RegWriteM = rw; ResultSrcM = src; LoadTypeM = lt;
      ByteOffM = off; ALUOutM = alu; ReadDataM = rd; PCPlus8M = pc8;
      WriteRegM = wreg;
   endtask

   function automatic vec_t mk(input logic v, input logic rw, input logic [1:0] src,
                               input logic [2:0] lt, input logic [1:0] off,
                               input logic [31:0] alu, input logic [31:0] rd,
                               input logic [31:0] pc8, input logic [4:0] wreg,
                               input logic [31:0] e_res, input logic e_rw,
                               input logic e_v);
      vec_t t;
      t.v = v; t.rw = rw; t.src = src; t.lt = lt; t.off = off; t.alu = alu;
      t.rd = rd; t.pc8 = pc8; t.wreg = wreg; t.e_res = e_res; t.e_rw = e_rw;
      t.e_v = e_v;
      return t;
   endfunction

   // Drive at the falling edge, capture at the rising edge, sample 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[16];

   initial begin
      // -- vector table: valid rw src lt off alu rd pc8 wreg | result rw v
      vecs[0]  = mk(1, 1, 2'b00, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 5'd3,  32'h1234_5678, 1, 1);
      vecs[1]  = mk(1, 1, 2'b11, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd4,  32'hDEAD_BEEF, 1, 1);
      vecs[2]  = mk(1, 1, 2'b01, 3'd3, 2'd2, 32'h0, 32'h1280_3456, 32'h0, 5'd5,  32'hFFFF_FF80, 1, 1);
      vecs[3]  = mk(1, 1, 2'b01, 3'd4, 2'd2, 32'h0, 32'h1280_3456, 32'h0, 5'd5,  32'h0000_0080, 1, 1);
      vecs[4]  = mk(1, 1, 2'b01, 3'd1, 2'd2, 32'h0, 32'h8001_7FFF, 32'h0, 5'd6,  32'hFFFF_8001, 1, 1);
      vecs[5]  = mk(1, 1, 2'b01, 3'd2, 2'd2, 32'h0, 32'h8001_7FFF, 32'h0, 5'd6,  32'h0000_8001, 1, 1);
      vecs[6]  = mk(1, 1, 2'b01, 3'd0, 2'd3, 32'h0, 32'h8001_7FFF, 32'h0, 5'd7,  32'h8001_7FFF, 1, 1);
      vecs[7]  = mk(1, 1, 2'b01, 3'd7, 2'd1, 32'h0, 32'hCAFE_F00D, 32'h0, 5'd8,  32'hCAFE_F00D, 1, 1);
      vecs[8]  = mk(1, 1, 2'b01, 3'd3, 2'd0, 32'h0, 32'h0000_007F, 32'h0, 5'd9,  32'h0000_007F, 1, 1);
      vecs[9]  = mk(1, 1, 2'b01, 3'd3, 2'd3, 32'h0, 32'h8500_0000, 32'h0, 5'd10, 32'hFFFF_FF85, 1, 1);
      vecs[10] = mk(1, 1, 2'b01, 3'd1, 2'd1, 32'h0, 32'h1234_9ABC, 32'h0, 5'd11, 32'hFFFF_9ABC, 1, 1);
      vecs[11] = mk(1, 1, 2'b10, 3'd0, 2'd0, 32'h1111_1111, 32'h0, 32'h0040_0010, 5'd31, 32'h0040_0010, 1, 1);
      vecs[12] = mk(1, 1, 2'b00, 3'd3, 2'd1, 32'h0000_00FF, 32'hFFFF_FFFF, 32'h0, 5'd12, 32'h0000_00FF, 1, 1);
      vecs[13] = mk(1, 1, 2'b00, 3'd0, 2'd0, 32'h0000_0005, 32'h0, 32'h0, 5'd0,  32'h0000_0005, 0, 1);
      vecs[14] = mk(0, 1, 2'b00, 3'd0, 2'd0, 32'h0000_0077, 32'h0, 32'h0, 5'd13, 32'h0000_0077, 0, 0);
      vecs[15] = mk(1, 0, 2'b01, 3'd4, 2'd1, 32'h0, 32'h0000_AB00, 32'h0, 5'd14, 32'h0000_00AB, 0, 1);

      // -- reset state, checked before any clock edge
      rst_n = 1'b0; StallW = 1'b0; FlushW = 1'b0;
      drive(1, 1, 2'b00, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd1);
      #2;
      expect_out(0, 0, 5'd0, 32'h0);
      compare_out("reset");
      step();
      expect_out(0, 0, 5'd0, 32'h0);
      compare_out("reset_edge");

      @(negedge clk);
      rst_n = 1'b1;

      // -- table-driven vectors
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(vecs[i].v, vecs[i].rw, vecs[i].src, vecs[i].lt, vecs[i].off,
               vecs[i].alu, vecs[i].rd, vecs[i].pc8, vecs[i].wreg);
         expect_out(vecs[i].e_v, vecs[i].e_rw, vecs[i].wreg, vecs[i].e_res);
         step();
         compare_out($sformatf("vec%0d", i));
      end

      // -- stall for 3 cycles with changing inputs, then stall+flush
      @(negedge clk);
      drive(1, 1, 2'b00, 3'd0, 2'd0, 32'hAAAA_5555, 32'h0, 32'h0, 5'd7);
      expect_out(1, 1, 5'd7, 32'hAAAA_5555);
      step();
      compare_out("stall_load");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         StallW = 1'b1;
         drive(k[0], 1, 2'(k + 1), 3'(k), 2'(k), 32'h111 * (k + 1),
               32'h8080_8080, 32'h4 * (k + 1), 5'(k + 20));
         expect_out(1, 1, 5'd7, 32'hAAAA_5555);
         step();
         compare_out($sformatf("stall%0d", k));
      end
      @(negedge clk);
      FlushW = 1'b1;
      expect_out(0, 0, 5'd7, 32'hAAAA_5555);
      step();
      compare_out("stall_flush");

      // flush without stall: data captured, enables cleared
      @(negedge clk);
      StallW = 1'b0;
      drive(1, 1, 2'b00, 3'd0, 2'd0, 32'h0000_0099, 32'h0, 32'h0, 5'd9);
      expect_out(0, 0, 5'd9, 32'h0000_0099);
      step();
      compare_out("flush_only");

      @(negedge clk);
      FlushW = 1'b0;
      drive(1, 1, 2'b00, 3'd0, 2'd0, 32'h0000_0042, 32'h0, 32'h0, 5'd2);
      expect_out(1, 1, 5'd2, 32'h0000_0042);
      step();
      compare_out("after_flush");

      // -- JAL, then hold-bypass registers one cycle later
      @(negedge clk);
      drive(1, 1, 2'b10, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0040_0010, 5'd31);
      expect_out(1, 1, 5'd31, 32'h0040_0010);
      step();
      compare_out("jal");
      @(negedge clk);
      drive(1, 1, 2'b00, 3'd0, 2'd0, 32'h0000_0123, 32'h0, 32'h0, 5'd15);
      expect_out(1, 1, 5'd15, 32'h0000_0123);
      step();
      compare_out("post_jal");
`ifdef WB_HOLD_BYPASS_EN
      check("hold.valid",  32'(HoldValidW), 32'h1);
      check("hold.reg",    32'(HoldRegW),   32'd31);
      check("hold.result", HoldResultW,     32'h0040_0010);
`endif

      // -- asynchronous reset between edges while ValidW=1
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      expect_out(0, 0, 5'd0, 32'h0);
      compare_out("async_reset");
`ifdef WB_HOLD_BYPASS_EN
      check("async_reset.hold_valid",  32'(HoldValidW), 32'h0);
      check("async_reset.hold_reg",    32'(HoldRegW),   32'h0);
      check("async_reset.hold_result", HoldResultW,     32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // -- reset during stall discards the held instruction
      @(negedge clk);
      drive(1, 1, 2'b00, 3'd0, 2'd0, 32'h0BAD_F00D, 32'h0, 32'h0, 5'd21);
      expect_out(1, 1, 5'd21, 32'h0BAD_F00D);
      step();
      compare_out("pre_stall_reset");
      @(negedge clk);
      StallW = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      expect_out(0, 0, 5'd0, 32'h0);
      compare_out("stall_reset");
      @(negedge clk);
      rst_n = 1'b1;
      expect_out(0, 0, 5'd0, 32'h0);
      step();
      compare_out("stall_after_reset");
      @(negedge clk);
      StallW = 1'b0;
      drive(1, 1, 2'b01, 3'd4, 2'd3, 32'h0, 32'hC300_0000, 32'h0, 5'd22);
      expect_out(1, 1, 5'd22, 32'h0000_00C3);
      step();
      compare_out("first_capture");

      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width in bits (multiple of 16, minimum 32).
REQ-002 SHALL have parameter REG_AW, default 5, register-file address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port StallW  input  1  hold the stage registers.
REQ-006 SHALL have port FlushW  input  1  invalidate the incoming instruction.
REQ-007 SHALL have port ValidM  input  1  MEM-stage instruction is real, not a bubble.
REQ-008 SHALL have port RegWriteM  input  1  instruction writes the register file.
REQ-009 SHALL have port ResultSrcM  input  2  result source: 00 ALU, 01 memory, 10 link (PC+8), 11 ALU.
REQ-010 SHALL have port LoadTypeM  input  3  load type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; all other codes act as LW.
REQ-011 SHALL have port ByteOffM  input  2  low address bits of the load.
REQ-012 SHALL have ports ALUOutM, ReadDataM and PCPlus8M  input  DATA_W each  candidate result values.
REQ-013 SHALL have port WriteRegM  input  REG_AW  destination register.
REQ-014 SHALL have port ValidW  output  1  stage holds a valid instruction.
REQ-015 SHALL have port RegWriteW  output  1  register-file write enable.
REQ-016 SHALL have port WriteRegW  output  REG_AW  register-file write address; it also feeds the hazard unit.
REQ-017 SHALL have port ResultW  output  DATA_W  register-file write data.

Function
REQ-018 SHALL capture all M-side inputs into internal W registers on each rising clk edge where StallW=0, giving 1-cycle latency from M inputs to W outputs.
REQ-019 SHALL hold every W register unchanged while StallW=1 and FlushW=0.
REQ-020 SHALL load ValidW=0 and RegWriteW=0 on an edge with FlushW=1, regardless of StallW; flush has priority over stall.
REQ-021 SHALL drive RegWriteW = registered RegWriteM AND registered ValidM AND (WriteRegW != 0); writes to register 0 are never issued.
REQ-022 SHALL compute ResultW combinationally from the registered fields, selected by the registered ResultSrc.
REQ-023 SHALL extract load data little-endian: halfword = bits [16*ByteOff[1] +: 16]; byte = bits [8*ByteOff +: 8].
REQ-024 SHALL sign-extend the extracted value to DATA_W for LH and LB, and zero-extend it for LHU and LBU.
REQ-025 SHALL pass ReadData unchanged for LW and ignore ByteOff for LW.
REQ-026 SHALL apply the load-type extraction only when ResultSrc=01.
REQ-027 SHALL keep ResultW and WriteRegW at their last captured values while ValidW=0; only the enables are cleared.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force all W registers to zero: ValidW=0, RegWriteW=0, WriteRegW=0, ResultW=0, and hold registers zero.
REQ-029 SHALL, on a reset asserted mid-stall, discard the held instruction; the first capture after release occurs on the first rising edge with rst_n=1 and StallW=0.

Configuration
REQ-030 SHALL, with macro WB_HOLD_BYPASS_EN defined, add outputs HoldValidW (1), HoldRegW (REG_AW) and HoldResultW (DATA_W) for decode-stage forwarding.
REQ-031 SHALL, with WB_HOLD_BYPASS_EN defined, on each rising edge with StallW=0, load HoldValidW <= RegWriteW, HoldRegW <= WriteRegW and HoldResultW <= ResultW, and hold these values during stall.
REQ-032 SHALL, without WB_HOLD_BYPASS_EN, omit these ports and registers entirely; all other behaviour is identical.

Verification
REQ-033 SHALL check: ResultSrc=01, LB, ByteOff=2, ReadData=0x12_80_34_56 -> ResultW=0xFFFFFF80 one cycle later; with LBU -> 0x00000080.
REQ-034 SHALL check: ResultSrc=01, LH, ByteOff=2, ReadData=0x8001_7FFF -> ResultW=0xFFFF8001; with LHU -> 0x00008001.
REQ-035 SHALL check: RegWriteM=1, ValidM=1, WriteRegM=0, ALUOut=0x5 -> RegWriteW=0, ValidW=1.
REQ-036 SHALL check: StallW=1 for 3 cycles with changing M inputs -> all W outputs constant; then StallW=1 and FlushW=1 together -> ValidW=0, RegWriteW=0.
REQ-037 SHALL check: JAL with ResultSrc=10, PCPlus8=0x0040_0010, WriteReg=31 -> ResultW=0x00400010 and RegWriteW=1; with WB_HOLD_BYPASS_EN defined -> HoldRegW=31 and HoldResultW=0x00400010 on the following cycle.
REQ-038 SHALL check: rst_n dropped asynchronously between clock edges while ValidW=1 -> all outputs zero immediately, with no clock edge required.
